// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and combo ordering for the truth-table sequencer.
// Define SEQ_GRAY_ORDER_EN to walk the input combinations in Gray order.
package seq_pkg;

  localparam int NUM_COMBOS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Maps step index to the {a,b} pair driven during that step.
  function automatic logic [1:0] combo(input logic [1:0] idx);
`ifdef SEQ_GRAY_ORDER_EN
    return {idx[1], idx[1] ^ idx[0]};
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Hold-window counter: expire is high on the last cycle of each window.
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (expire) cnt <= '0;
      else        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives a/b through all four combinations, samples c at the end of each
// hold window and compares the captured table. Option: SEQ_GRAY_ORDER_EN.
module truth_table_sequencer
  import seq_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] EXPECTED    = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       c_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] truth
);

  state_t     state;
  logic [1:0] idx;
  logic [1:0] cur;
  logic       expire;
  logic [3:0] truth_next;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == IDLE),
    .enable (state == DRIVE),
    .expire (expire)
  );

  assign cur = combo(idx);

  // Table including the sample taken on this edge, so pass sees all four bits.
  always_comb begin
    truth_next      = truth;
    truth_next[cur] = c_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_out <= 1'b0;
      b_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      truth <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_out <= 1'b0;
          b_out <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            state          <= DRIVE;
            idx            <= '0;
            busy           <= 1'b1;
            truth          <= '0;
            pass           <= 1'b0;
            {a_out, b_out} <= combo(2'd0);
          end
        end
        DRIVE: begin
          if (expire) begin
            truth <= truth_next;
            if (idx == 2'(NUM_COMBOS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (truth_next == EXPECTED);
            end else begin
              idx            <= idx + 2'd1;
              {a_out, b_out} <= combo(idx + 2'd1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          a_out <= 1'b0;
          b_out <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: two sequencer instances (hold 10 and hold 1) with
// AND/XOR/OR models on c_in and hand-computed truth tables.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sel;
  int         mode;
  int         errors = 0;
  int         checks = 0;

  logic       a0, b0, busy0, done0, pass0, c0;
  logic       a1, b1, busy1, done1, pass1, c1;
  logic [3:0] truth0, truth1;

  logic       oa, ob, obusy, odone, opass;
  logic [3:0] otruth;

  always #5 clk = ~clk;

  function automatic logic model(input int m, input logic a, input logic b);
    case (m)
      0:       return a & b;
      1:       return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // Expected {a,b} for step k, hand-tabulated.
  function automatic logic [1:0] exp_ab(input int k);
`ifdef SEQ_GRAY_ORDER_EN
    case (k)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
`else
    case (k)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b10;
      default: return 2'b11;
    endcase
`endif
  endfunction

  assign c0 = model(mode, a0, b0);
  assign c1 = model(mode, a1, b1);

  assign oa     = sel ? a1     : a0;
  assign ob     = sel ? b1     : b0;
  assign obusy  = sel ? busy1  : busy0;
  assign odone  = sel ? done1  : done0;
  assign opass  = sel ? pass1  : pass0;
  assign otruth = sel ? truth1 : truth0;

  truth_table_sequencer #(.HOLD_CYCLES(10), .EXPECTED(4'b1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .c_in(c0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0), .truth(truth0)
  );

  truth_table_sequencer #(.HOLD_CYCLES(1), .EXPECTED(4'b1000)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .c_in(c1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1), .truth(truth1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; one full run on the selected instance.
  task automatic run(input string tag, input int hold, input bit keep_start,
                     input logic [3:0] et, input logic ep);
    int pulses = 0;
    start = 1'b1;
    for (int i = 0; i <= 4 * hold + 1; i++) begin
      @(negedge clk);
      if (i == 0 && !keep_start) start = 1'b0;
      if (odone) pulses++;
      if (i < 4 * hold) begin
        check({tag, " busy"}, obusy, 1'b1);
        check({tag, " done_low"}, odone, 1'b0);
        check({tag, " ab"}, {oa, ob}, exp_ab(i / hold));
      end else if (i == 4 * hold) begin
        check({tag, " busy_end"}, obusy, 1'b0);
        check({tag, " done"}, odone, 1'b1);
        check({tag, " truth"}, otruth, et);
        check({tag, " pass"}, opass, ep);
      end else begin
        check({tag, " done_clear"}, odone, 1'b0);
        check({tag, " idle_busy"}, obusy, 1'b0);
        check({tag, " idle_ab"}, {oa, ob}, 2'b00);
        check({tag, " truth_hold"}, otruth, et);
        check({tag, " pass_hold"}, opass, ep);
      end
    end
    check({tag, " pulses"}, pulses, 1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    mode  = 0;
    repeat (2) @(negedge clk);
    check("rst busy", busy0, 1'b0);
    check("rst done", done0, 1'b0);
    check("rst pass", pass0, 1'b0);
    check("rst ab", {a0, b0}, 2'b00);
    check("rst truth", truth0, 4'b0000);
    check("rst h1 truth", truth1, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0;
    run("and", 10, 1'b0, 4'b1000, 1'b1);
    repeat (2) @(negedge clk);

    mode = 1;
    run("xor", 10, 1'b0, 4'b0110, 1'b0);
    repeat (2) @(negedge clk);

    sel  = 1'b1;
    mode = 2;
    run("or_h1", 1, 1'b0, 4'b1110, 1'b0);
    repeat (2) @(negedge clk);
    sel  = 1'b0;

    // start held high: second run only after passing back through IDLE
    mode = 0;
    run("hold_start", 10, 1'b1, 4'b1000, 1'b1);
    @(negedge clk);
    check("restart busy", busy0, 1'b1);
    check("restart truth_clr", truth0, 4'b0000);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    check("restart done_seen", seen, 1'b1);
    check("restart truth", truth0, 4'b1000);
    repeat (2) @(negedge clk);

    // reset at cycle 15 of a run aborts without a done pulse
    mode  = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", busy0, 1'b0);
    check("abort ab", {a0, b0}, 2'b00);
    check("abort truth", truth0, 4'b0000);
    check("abort done", done0, 1'b0);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    check("abort no_done", seen, 1'b0);
    mode = 0;
    run("after_abort", 10, 1'b0, 4'b1000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
